// File: rtl/mixer_stereo_ramp.sv
// -----------------------------------------------------------------------------
// mixer_stereo_ramp
//   Stereo serial-audio gain stage. Left-justified serial words are
//   deserialised per channel, multiplied by a per-channel gain (unity =
//   2**(W_LEVEL-1)), clamped to the sample range, and shifted back out
//   during the same channel's slot of the following frame.
//
//   Build option: define MIXER_RAMP_EN to make the gain move one step per
//   frame toward its target instead of jumping straight to it.
//
// Ports
//   clk          system clock, all logic on its rising edge
//   rst          synchronous active-high reset
//   bclk         serial bit clock (synchronous to clk, <= clk/4)
//   lrclk        channel select, 0 = left, 1 = right
//   level_l/_r   target gain per channel (unsigned)
//   mute         forces both targets to 0
//   in           serial input data, MSB first
//   out          serial processed data
//   out_p        last processed word, parallel
//   out_p_valid  one-clk pulse when out_p updates
//   sat          one-clk pulse alongside out_p_valid when that word clamped
// -----------------------------------------------------------------------------
module mixer_stereo_ramp #(
   parameter int W_SAMPLE = 32,
   parameter int W_LEVEL  = 7
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                bclk,
   input  logic                lrclk,
   input  logic [W_LEVEL-1:0]  level_l,
   input  logic [W_LEVEL-1:0]  level_r,
   input  logic                mute,
   input  logic                in,
   output logic                out,
   output logic [W_SAMPLE-1:0] out_p,
   output logic                out_p_valid,
   output logic                sat
);

   localparam int KW = $clog2(W_SAMPLE + 1);
   localparam int WP = W_SAMPLE + W_LEVEL + 1;
   localparam logic [KW-1:0] IDX_MAX = KW'(W_SAMPLE);
   localparam logic [KW-1:0] IDX_TOP = KW'(W_SAMPLE - 1);

   // Returns {saturated, word}: word * gain, arithmetic shift by W_LEVEL-1,
   // clamped to the signed sample range.
   function automatic logic [W_SAMPLE:0] scale_word(input logic [W_SAMPLE-1:0] word,
                                                    input logic [W_LEVEL-1:0]  gain);
      logic [WP-1:0]      prod;
      logic [WP-1:0]      shifted;
      logic [W_LEVEL+1:0] upper;
      logic [W_SAMPLE:0]  res;
      // Operands are extended to the product width so the truncated unsigned
      // product equals the two's-complement product.
      prod    = {{(W_LEVEL+1){word[W_SAMPLE-1]}}, word} * {{(W_SAMPLE+1){1'b0}}, gain};
      shifted = $signed(prod) >>> (W_LEVEL-1);
      upper   = shifted[WP-1:W_SAMPLE-1];
      if ((&upper) || (~|upper)) begin
         res = {1'b0, shifted[W_SAMPLE-1:0]};
      end else if (shifted[WP-1]) begin
         res = {1'b1, 1'b1, {(W_SAMPLE-1){1'b0}}};
      end else begin
         res = {1'b1, 1'b0, {(W_SAMPLE-1){1'b1}}};
      end
      return res;
   endfunction

`ifdef MIXER_RAMP_EN
   // One gain step toward the target, holding once it is reached.
   function automatic logic [W_LEVEL-1:0] ramp_step(input logic [W_LEVEL-1:0] cur,
                                                    input logic [W_LEVEL-1:0] tgt);
      logic [W_LEVEL-1:0] nxt;
      if (cur < tgt) begin
         nxt = cur + {{(W_LEVEL-1){1'b0}}, 1'b1};
      end else if (cur > tgt) begin
         nxt = cur - {{(W_LEVEL-1){1'b0}}, 1'b1};
      end else begin
         nxt = cur;
      end
      return nxt;
   endfunction
`endif

   logic                bclk_d_r, lr_prev_r, lr_seen_r, primed_r;
   logic [KW-1:0]       bit_idx_r;
   logic [W_SAMPLE-1:0] shift_r, word_l_r, word_r_r, out_p_r;
   logic [W_LEVEL-1:0]  gain_l_r, gain_r_r;
   logic                out_r, valid_r, sat_r;

   logic                bit_ev_s, slot_bd_s, frame_bd_s, scale_en_s;
   logic [W_LEVEL-1:0]  gain_end_s, tgt_l_s, tgt_r_s;
   logic [W_SAMPLE:0]   scaled_s;
   logic [KW-1:0]       cur_idx_s;
   logic [W_SAMPLE-1:0] out_word_s;

   logic                bclk_d_nx, lr_prev_nx, lr_seen_nx, primed_nx;
   logic [KW-1:0]       bit_idx_nx;
   logic [W_SAMPLE-1:0] shift_nx, word_l_nx, word_r_nx, out_p_nx;
   logic [W_LEVEL-1:0]  gain_l_nx, gain_r_nx;
   logic                out_nx, valid_nx, sat_nx;

   // Event detection and next-state computation for the whole datapath.
   always_comb begin
      bit_ev_s   = bclk & ~bclk_d_r;
      // lr_seen_r suppresses a boundary on the very first bit event after
      // reset, so the partial slot in progress at reset is never scaled.
      slot_bd_s  = bit_ev_s & lr_seen_r & (lrclk != lr_prev_r);
      frame_bd_s = slot_bd_s & ~lrclk;
      scale_en_s = slot_bd_s & primed_r;
      gain_end_s = lr_prev_r ? gain_r_r : gain_l_r;
      scaled_s   = scale_word(shift_r, gain_end_s);
      cur_idx_s  = slot_bd_s ? {KW{1'b0}} : bit_idx_r;
      out_word_s = lrclk ? word_r_r : word_l_r;
      tgt_l_s    = mute ? {W_LEVEL{1'b0}} : level_l;
      tgt_r_s    = mute ? {W_LEVEL{1'b0}} : level_r;

      bclk_d_nx  = bclk;
      lr_prev_nx = bit_ev_s ? lrclk : lr_prev_r;
      lr_seen_nx = lr_seen_r | bit_ev_s;
      primed_nx  = primed_r | slot_bd_s;

      // Deserialiser is cleared at each boundary so short slots zero-fill.
      shift_nx   = shift_r;
      bit_idx_nx = bit_idx_r;
      if (slot_bd_s) begin
         shift_nx             = {W_SAMPLE{1'b0}};
         shift_nx[W_SAMPLE-1] = in;
         bit_idx_nx           = {{(KW-1){1'b0}}, 1'b1};
      end else if (bit_ev_s && (bit_idx_r < IDX_MAX)) begin
         shift_nx[IDX_TOP - bit_idx_r] = in;
         bit_idx_nx                    = bit_idx_r + {{(KW-1){1'b0}}, 1'b1};
      end else begin
         shift_nx   = shift_r;
         bit_idx_nx = bit_idx_r;
      end

      if (bit_ev_s) begin
         out_nx = (cur_idx_s < IDX_MAX) ? out_word_s[IDX_TOP - cur_idx_s] : 1'b0;
      end else begin
         out_nx = out_r;
      end

      word_l_nx = (scale_en_s && !lr_prev_r) ? scaled_s[W_SAMPLE-1:0] : word_l_r;
      word_r_nx = (scale_en_s &&  lr_prev_r) ? scaled_s[W_SAMPLE-1:0] : word_r_r;
      out_p_nx  = scale_en_s ? scaled_s[W_SAMPLE-1:0] : out_p_r;
      valid_nx  = scale_en_s;
      sat_nx    = scale_en_s & scaled_s[W_SAMPLE];

      // The gain register changes on the same edge the ending right word is
      // scaled, so that word still uses the previous frame's gain.
`ifdef MIXER_RAMP_EN
      if (frame_bd_s) begin
         gain_l_nx = ramp_step(gain_l_r, tgt_l_s);
         gain_r_nx = ramp_step(gain_r_r, tgt_r_s);
      end else begin
         gain_l_nx = gain_l_r;
         gain_r_nx = gain_r_r;
      end
`else
      if (frame_bd_s) begin
         gain_l_nx = tgt_l_s;
         gain_r_nx = tgt_r_s;
      end else begin
         gain_l_nx = gain_l_r;
         gain_r_nx = gain_r_r;
      end
`endif
   end

   // State registers; reset takes priority over every pending update.
   always_ff @(posedge clk) begin
      if (rst) begin
         bclk_d_r  <= 1'b0;
         lr_prev_r <= 1'b0;
         lr_seen_r <= 1'b0;
         primed_r  <= 1'b0;
         bit_idx_r <= {KW{1'b0}};
         shift_r   <= {W_SAMPLE{1'b0}};
         word_l_r  <= {W_SAMPLE{1'b0}};
         word_r_r  <= {W_SAMPLE{1'b0}};
         out_p_r   <= {W_SAMPLE{1'b0}};
         gain_l_r  <= {W_LEVEL{1'b0}};
         gain_r_r  <= {W_LEVEL{1'b0}};
         out_r     <= 1'b0;
         valid_r   <= 1'b0;
         sat_r     <= 1'b0;
      end else begin
         bclk_d_r  <= bclk_d_nx;
         lr_prev_r <= lr_prev_nx;
         lr_seen_r <= lr_seen_nx;
         primed_r  <= primed_nx;
         bit_idx_r <= bit_idx_nx;
         shift_r   <= shift_nx;
         word_l_r  <= word_l_nx;
         word_r_r  <= word_r_nx;
         out_p_r   <= out_p_nx;
         gain_l_r  <= gain_l_nx;
         gain_r_r  <= gain_r_nx;
         out_r     <= out_nx;
         valid_r   <= valid_nx;
         sat_r     <= sat_nx;
      end
   end

   assign out         = out_r;
   assign out_p       = out_p_r;
   assign out_p_valid = valid_r;
   assign sat         = sat_r;

endmodule

// File: tb/tb_mixer_stereo_ramp.sv
// -----------------------------------------------------------------------------
// tb_mixer_stereo_ramp
//   Drives left-justified serial frames into mixer_stereo_ramp and checks the
//   parallel results through a scoreboard and the serial output bit by bit
//   against a slot-level reference model.
// -----------------------------------------------------------------------------
module tb_mixer_stereo_ramp;

   logic        clk = 1'b0;
   logic        rst, bclk, lrclk, mute, in_bit;
   logic [6:0]  level_l, level_r;
   logic        out;
   logic [31:0] out_p;
   logic        out_p_valid, sat;

   always #5 clk = ~clk;

   mixer_stereo_ramp #(.W_SAMPLE(32), .W_LEVEL(7)) dut (
      .clk(clk), .rst(rst), .bclk(bclk), .lrclk(lrclk),
      .level_l(level_l), .level_r(level_r), .mute(mute), .in(in_bit),
      .out(out), .out_p(out_p), .out_p_valid(out_p_valid), .sat(sat)
   );

   typedef struct packed {
      logic [31:0] word;
      logic        sat;
   } exp_t;

   exp_t        sb_q[$];
   int          total = 0;
   int          bad = 0;

   // Reference model state (slot granularity)
   int          gain_m[2];
   logic [31:0] oreg_m[2];
   bit          seen_m, have_prev_m;
   int          prev_ch_m;
   logic [31:0] prev_word_m;

   function automatic exp_t model_scale(input logic [31:0] w, input int g);
      longint p, q;
      exp_t   e;
      p = longint'($signed(w)) * longint'(g);
      q = p >>> 6;
      if (q > 64'sd2147483647) begin
         e.word = 32'h7FFF_FFFF; e.sat = 1'b1;
      end else if (q < -64'sd2147483648) begin
         e.word = 32'h8000_0000; e.sat = 1'b1;
      end else begin
         e.word = q[31:0]; e.sat = 1'b0;
      end
      return e;
   endfunction

   task automatic model_reset();
      gain_m[0] = 0; gain_m[1] = 0;
      oreg_m[0] = 32'h0; oreg_m[1] = 32'h0;
      seen_m = 1'b0; have_prev_m = 1'b0;
      prev_ch_m = 0; prev_word_m = 32'h0;
   endtask

   task automatic model_frame_gain();
      int tgt[2];
      tgt[0] = mute ? 0 : int'(level_l);
      tgt[1] = mute ? 0 : int'(level_r);
      for (int c = 0; c < 2; c++) begin
`ifdef MIXER_RAMP_EN
         if (gain_m[c] < tgt[c]) gain_m[c] = gain_m[c] + 1;
         else if (gain_m[c] > tgt[c]) gain_m[c] = gain_m[c] - 1;
`else
         gain_m[c] = tgt[c];
`endif
      end
   endtask

   task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   // One serial slot of nbits on channel ch; rst_at >= 0 pulses reset after that bit.
   task automatic send_slot(input int ch, input logic [31:0] data, input int nbits, input int rst_at);
      exp_t        e;
      bit          rst_hit;
      bit          b;
      logic        want;
      logic [31:0] mask;
      rst_hit = 1'b0;
      if (seen_m) begin
         if (have_prev_m) begin
            e = model_scale(prev_word_m, gain_m[prev_ch_m]);
            sb_q.push_back(e);
            oreg_m[prev_ch_m] = e.word;
         end
         if (ch == 0) model_frame_gain();
      end
      for (int k = 0; k < nbits; k++) begin
         b = (k < 32) ? data[31-k] : 1'($urandom);
         lrclk = ch[0]; in_bit = b; bclk = 1'b1;
         @(negedge clk); @(negedge clk);
         want = (k < 32) ? oreg_m[ch][31-k] : 1'b0;
         total++;
         if (out !== want) begin
            bad++;
            $display("FAIL serial ch=%0d bit=%0d got=%b want=%b", ch, k, out, want);
         end
         bclk = 1'b0;
         if (k == rst_at) begin
            @(negedge clk); rst = 1'b1;
            @(negedge clk); rst = 1'b0;
            model_reset();
            rst_hit = 1'b1;
            check_val("rst_out_p", out_p, 32'h0);
            check_val("rst_out", {31'h0, out}, 32'h0);
            check_val("rst_valid", {31'h0, out_p_valid}, 32'h0);
            @(negedge clk);
         end else begin
            @(negedge clk); @(negedge clk);
         end
      end
      mask = (nbits >= 32) ? 32'hFFFF_FFFF : ~(32'hFFFF_FFFF >> nbits);
      have_prev_m = seen_m && !rst_hit;
      seen_m = 1'b1;
      prev_ch_m = ch;
      prev_word_m = data & mask;
   endtask

   task automatic send_frame(input logic [31:0] lw, input int ln, input logic [31:0] rw, input int rn);
      send_slot(0, lw, ln, -1);
      send_slot(1, rw, rn, -1);
   endtask

   function automatic int rand_len();
      return ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 40)) : 32;
   endfunction

   // Scoreboard monitor: pops one expectation per out_p_valid pulse.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (out_p_valid) begin
            total++;
            if (sb_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_valid out_p=%h sat=%b", out_p, sat);
            end else begin
               e = sb_q.pop_front();
               if (out_p !== e.word || sat !== e.sat) begin
                  bad++;
                  $display("FAIL out_p got=%h sat=%b want=%h sat=%b", out_p, sat, e.word, e.sat);
               end
            end
         end else if (sat) begin
            total++;
            bad++;
            $display("FAIL sat_without_valid sat=%b", sat);
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; bclk = 1'b0; lrclk = 1'b1; in_bit = 1'b0;
      level_l = 7'd0; level_r = 7'd0; mute = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_val("reset_out", {31'h0, out}, 32'h0);
      check_val("reset_out_p", out_p, 32'h0);
      check_val("reset_valid", {31'h0, out_p_valid}, 32'h0);
      check_val("reset_sat", {31'h0, sat}, 32'h0);

      // Partial right slot, discarded
      send_slot(1, $urandom, 12, -1);

      // Directed frames: unity, half gain, saturation, short slot, mute
      level_l = 7'd64; level_r = 7'd127;
      send_frame(32'h1234_5678, 32, 32'h7FFF_FFFF, 32);
      level_l = 7'd32;
      send_frame(32'h8000_0000, 32, 32'h8000_0000, 32);
      send_frame(32'h1234_5678, 32, $urandom, 32);
      level_l = 7'd64;
      send_frame(32'h1234_56A5, 24, 32'h0000_0001, 32);
      mute = 1'b1;
      send_frame($urandom, 32, $urandom, 32);
      send_frame($urandom, 32, $urandom, 32);
      mute = 1'b0;

      // Random frames
      for (int f = 0; f < 24; f++) begin
         level_l = 7'($urandom_range(0, 127));
         level_r = 7'($urandom_range(0, 127));
         mute = ($urandom_range(0, 7) == 0);
         send_frame($urandom, rand_len(), $urandom, rand_len());
      end

      // Reset in the middle of a left slot, then recover
      mute = 1'b0; level_l = 7'd64; level_r = 7'd96;
      send_slot(0, $urandom, 32, 10);
      send_slot(1, $urandom, 32, -1);
      for (int f = 0; f < 8; f++) begin
         level_l = 7'($urandom_range(0, 127));
         level_r = 7'($urandom_range(0, 127));
         send_frame($urandom, rand_len(), $urandom, rand_len());
      end

      // Flush the last word, then leave the clocks stopped
      send_slot(0, $urandom, 4, -1);
      repeat (20) @(negedge clk);
      check_val("queue_drained", sb_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mixer_stereo_ramp.md
MIXER_STEREO_RAMP -- requirements
Module: mixer_stereo_ramp

Interface
REQ-001 Parameter W_SAMPLE, default 32: bits per serial sample word, two's complement, MSB first.
REQ-002 Parameter W_LEVEL, default 7: level width; unity gain = 2**(W_LEVEL-1).
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 bclk  input  1  serial bit clock, synchronous to clk, at most clk/4.
REQ-006 lrclk  input  1  channel select: 0 left, 1 right.
REQ-007 level_l, level_r  input  W_LEVEL each  target gain per channel, unsigned.
REQ-008 mute  input  1  forces target gain 0 on both channels.
REQ-009 in  input  1  serial input data.
REQ-010 out  output  1  serial processed data.
REQ-011 out_p  output  W_SAMPLE  last processed word, parallel.
REQ-012 out_p_valid  output  1  one-clk pulse when out_p updates.
REQ-013 sat  output  1  one-clk pulse with out_p_valid when that word saturated.

Function
REQ-014 Bit event = bclk rising edge, detected as bclk high and previous-clk bclk low; all serial activity occurs only on bit events.
REQ-015 Slot boundary = bit event where lrclk differs from its value at the previous bit event; the bit sampled at that event is bit 0 (MSB) of the new slot (left-justified).
REQ-016 Frame boundary = slot boundary into lrclk=0.
REQ-017 Input: bits 0..W_SAMPLE-1 of a slot shift into a deserialiser; bits beyond W_SAMPLE are ignored; a short slot zero-fills missing LSBs.
REQ-018 At each slot boundary the completed word of the ending channel is scaled: product = word * gain_cur(ch), signed (W_SAMPLE+W_LEVEL+1) bits, arithmetic right shift by W_LEVEL-1.
REQ-019 Scaled result outside [-2**(W_SAMPLE-1), 2**(W_SAMPLE-1)-1] is clamped to the nearer bound and sat pulses.
REQ-020 Scaled result is written to that channel's output register, out_p, and out_p_valid pulses, within 2 clk of the slot boundary and before the next bit event.
REQ-021 out drives, at each bit event, bit k (k = bit index within current slot) of the current channel's output register; k >= W_SAMPLE drives 0.
REQ-022 Latency: a word input in slot of channel c appears on out during the next slot of channel c (one frame).
REQ-023 Target per channel = 0 if mute else level_l / level_r, sampled at each frame boundary.
REQ-024 gain_cur updates only at frame boundaries, before the first scaling of the new frame uses it.
REQ-025 lrclk or bclk stopped: state holds, no out_p_valid.

Reset
REQ-026 rst high for one clk clears: deserialiser, both output registers, gain_cur to 0, bit index to 0, edge-detect history to 0; out, out_p, out_p_valid, sat = 0.
REQ-027 After rst deassertion the first lrclk transition seen is a slot boundary; the partial slot before it is discarded (no out_p_valid).
REQ-028 rst asserted mid-slot overrides all pending updates in that clk.

Configuration
REQ-029 Macro MIXER_RAMP_EN defined: at each frame boundary gain_cur moves one step toward target (+1 or -1), holds when equal.
REQ-030 MIXER_RAMP_EN undefined: gain_cur = target at each frame boundary; no ramp logic synthesised.

Verification (W_SAMPLE=32, W_LEVEL=7, 32 bclk per slot)
REQ-031 level_l=64, ramp off, left in 0x12345678 -> next-frame left out 0x12345678, out_p 0x12345678, sat 0.
REQ-032 level_l=32, in 0x80000000 -> out 0xC0000000; level_l=32, in 0x12345678 -> 0x091A2B3C.
REQ-033 level_r=127, right in 0x7FFFFFFF -> out 0x7FFFFFFF, sat pulses; in 0x80000000 -> 0x80000000, sat pulses.
REQ-034 MIXER_RAMP_EN, reset then level_l=64 constant -> gain_cur 1,2,..64 over 64 frames; mute=1 -> decrements 1 per frame to 0, out 0.
REQ-035 rst pulsed at bit 10 of a left slot -> out 0, no out_p_valid until first complete slot after next lrclk edge.
REQ-036 Slot of 24 bclk, in 0x123456 MSB-aligned, level 64 -> word 0x12345600, out bits 24..31 not driven out (slot ends).
